lab2_proc_iter_muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit with val/rdy request and response streams.

---
 rtl/lab2_proc_iter_muldiv_unit.sv | 143 ++++++++++++++
 tb/tb_lab2_proc_iter_muldiv_unit.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab2_proc_iter_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle shift-add multiply and
// restoring divide over a shared 2N-bit working register, val/rdy on both sides.
module lab2_proc_iter_muldiv_unit #(
    parameter int p_nbits     = 32,
    parameter int p_tag_nbits = 5
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   req_val,
    output logic                   req_rdy,
    input  logic [2:0]             req_op,
    input  logic [p_nbits-1:0]     req_a,
    input  logic [p_nbits-1:0]     req_b,
    input  logic [p_tag_nbits-1:0] req_tag,
    input  logic                   squash,
    output logic                   resp_val,
    input  logic                   resp_rdy,
    output logic [p_nbits-1:0]     resp_data,
    output logic [p_tag_nbits-1:0] resp_tag,
    output logic                   busy
);

    localparam int N  = p_nbits;
    localparam int CW = $clog2(N);
    localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                 state_q, state_d;
    logic [2:0]             op_q, op_d;
    logic                   neg_q, neg_d;
    logic [2*N-1:0]         p_q, p_d;
    logic [N-1:0]           b_q, b_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [p_tag_nbits-1:0] tag_q, tag_d;
    logic [N-1:0]           data_q, data_d;

    logic           req_fire;
    logic           a_signed, b_signed, a_neg, b_neg;
    logic [N-1:0]   a_mag, b_mag;
    logic           div_zero, div_ovf;
    logic [N-1:0]   fast_val;
    logic [N:0]     mul_sum;
    logic [N+1:0]   div_diff;
    logic [2*N-1:0] step_p, prod_fix;
    logic [N-1:0]   div_sel, div_fix, fin_val;

    assign req_rdy   = !squash && (state_q == IDLE || (state_q == DONE && resp_rdy));
    assign req_fire  = req_val && req_rdy;
    assign resp_val  = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign resp_data = data_q;
    assign resp_tag  = tag_q;

    // Both operations run on magnitudes; the sign is reapplied once at the end.
    assign a_signed = !(req_op == 3'd3 || req_op == 3'd5 || req_op == 3'd7);
    assign b_signed = a_signed && (req_op != 3'd2);
    assign a_neg    = a_signed && req_a[N-1];
    assign b_neg    = b_signed && req_b[N-1];
    assign a_mag    = a_neg ? -req_a : req_a;
    assign b_mag    = b_neg ? -req_b : req_b;
    assign div_zero = req_op[2] && (req_b == '0);
    assign div_ovf  = req_op[2] && !req_op[0] && (req_a == MIN_NEG) && (&req_b);
    assign fast_val = div_zero ? (req_op[1] ? req_a : {N{1'b1}})
                               : (req_op[1] ? {N{1'b0}} : MIN_NEG);

    // Upper half holds the accumulator / partial remainder, lower half the multiplier / quotient.
    assign mul_sum  = {1'b0, p_q[2*N-1:N]} + (p_q[0] ? {1'b0, b_q} : {(N+1){1'b0}});
    assign div_diff = {1'b0, p_q[2*N-1:N-1]} - {2'b00, b_q};
    assign step_p   = op_q[2] ? (div_diff[N+1] ? {p_q[2*N-2:0], 1'b0}
                                               : {div_diff[N-1:0], p_q[N-2:0], 1'b1})
                              : {mul_sum, p_q[N-1:1]};

    assign prod_fix = neg_q ? -step_p : step_p;
    assign div_sel  = op_q[1] ? step_p[2*N-1:N] : step_p[N-1:0];
    assign div_fix  = neg_q ? -div_sel : div_sel;
    assign fin_val  = op_q[2] ? div_fix
                              : ((op_q[1:0] == 2'd0) ? prod_fix[N-1:0] : prod_fix[2*N-1:N]);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        neg_d   = neg_q;
        p_d     = p_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;
        data_d  = data_q;
        case (state_q)
            CALC: begin
                p_d   = step_p;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = DONE;
                    data_d  = fin_val;
                end
            end
            DONE: begin
                if (resp_rdy) state_d = IDLE;
            end
            default: ;
        endcase
        // A fire while DONE is the zero-bubble handoff: the old response leaves this edge.
        if (req_fire) begin
            op_d  = req_op;
            tag_d = req_tag;
            neg_d = (req_op[2] && req_op[1]) ? a_neg : (a_neg ^ b_neg);
            p_d   = {{N{1'b0}}, a_mag};
            b_d   = b_mag;
            cnt_d = CW'(N - 1);
            if (div_zero || div_ovf) begin
                state_d = DONE;
                data_d  = fast_val;
            end else begin
                state_d = CALC;
            end
        end
        if (squash) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            neg_q   <= 1'b0;
            p_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            p_q     <= p_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_lab2_proc_iter_muldiv_unit.sv
// Directed bench for the iterative mul/div unit (32-bit instance) plus an 8-bit
// instance swept with random operands against a reference model.
module tb_lab2_proc_iter_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset_n;

    logic        req_val, req_rdy, squash, resp_val, resp_rdy, busy;
    logic [2:0]  req_op;
    logic [31:0] req_a, req_b, resp_data;
    logic [4:0]  req_tag, resp_tag;

    logic        val8, rdy8_req, squash8, rval8, rdy8, busy8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, data8;
    logic [4:0]  tag8, rtag8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lab2_proc_iter_muldiv_unit #(.p_nbits(32), .p_tag_nbits(5)) dut32 (
        .clk(clk), .reset_n(reset_n),
        .req_val(req_val), .req_rdy(req_rdy), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .squash(squash),
        .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_data(resp_data),
        .resp_tag(resp_tag), .busy(busy)
    );

    lab2_proc_iter_muldiv_unit #(.p_nbits(8), .p_tag_nbits(5)) dut8 (
        .clk(clk), .reset_n(reset_n),
        .req_val(val8), .req_rdy(rdy8_req), .req_op(op8),
        .req_a(a8), .req_b(b8), .req_tag(tag8),
        .squash(squash8),
        .resp_val(rval8), .resp_rdy(rdy8), .resp_data(data8),
        .resp_tag(rtag8), .busy(busy8)
    );

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] tag);
        req_val = 1'b1;
        req_op  = op;
        req_a   = a;
        req_b   = b;
        req_tag = tag;
    endtask

    // Counts sampled cycles from the fire edge until resp_val appears.
    task automatic waitResp(input string name, output int cycles);
        cycles = 1;
        while (!resp_val && cycles < 100) begin
            tick;
            cycles++;
        end
        checkOutput({name, "_resp_val"}, resp_val, 1'b1);
    endtask

    task automatic runOp(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag,
                         input logic [31:0] expected, input int exp_cycles);
        int cyc;
        applyStimulus(op, a, b, tag);
        tick;
        req_val = 1'b0;
        waitResp(name, cyc);
        checkOutput({name, "_data"}, resp_data, expected);
        checkOutput({name, "_tag"}, resp_tag, tag);
        checkOutput({name, "_latency"}, cyc, exp_cycles);
        tick;
    endtask

    function automatic logic [7:0] refModel8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        longint sa, sb, ua, ub;
        logic signed [63:0] p;
        logic [7:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({56'd0, a});
        ub = longint'({56'd0, b});
        r  = 8'h00;
        case (op)
            3'd0: begin p = sa * sb; r = p[7:0];  end
            3'd1: begin p = sa * sb; r = p[15:8]; end
            3'd2: begin p = sa * ub; r = p[15:8]; end
            3'd3: begin p = ua * ub; r = p[15:8]; end
            3'd4: begin
                if (b == 8'h00) r = 8'hFF;
                else if (a == 8'h80 && b == 8'hFF) r = 8'h80;
                else begin p = sa / sb; r = p[7:0]; end
            end
            3'd5: begin
                if (b == 8'h00) r = 8'hFF;
                else begin p = ua / ub; r = p[7:0]; end
            end
            3'd6: begin
                if (b == 8'h00) r = a;
                else if (a == 8'h80 && b == 8'hFF) r = 8'h00;
                else begin p = sa % sb; r = p[7:0]; end
            end
            default: begin
                if (b == 8'h00) r = a;
                else begin p = ua % ub; r = p[7:0]; end
            end
        endcase
        return r;
    endfunction

    function automatic logic [7:0] pickOperand8;
        case ($urandom_range(0, 7))
            0:       return 8'h00;
            1:       return 8'h80;
            2:       return 8'hFF;
            3:       return 8'h01;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        int cyc;
        int seen;
        int guard;
        logic got, checked;
        logic [7:0] exp8;

        reset_n  = 1'b0;
        req_val  = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
        squash   = 1'b0; resp_rdy = 1'b1;
        val8     = 1'b0; op8 = '0; a8 = '0; b8 = '0; tag8 = '0;
        squash8  = 1'b0; rdy8 = 1'b1;
        #3;
        checkOutput("reset_resp_val", resp_val, 1'b0);
        checkOutput("reset_resp_data", resp_data, 32'h0);
        checkOutput("reset_resp_tag", resp_tag, 5'h0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset8_resp_val", rval8, 1'b0);
        #9;
        reset_n = 1'b1;
        tick;
        checkOutput("idle_req_rdy", req_rdy, 1'b1);

        runOp("mul_neg",    3'd0, 32'h00000007, 32'hFFFFFFFD, 5'h13, 32'hFFFFFFEB, 33);
        runOp("mul_low",    3'd0, 32'h12345678, 32'h00000010, 5'h01, 32'h23456780, 33);
        runOp("mulh_min",   3'd1, 32'h80000000, 32'h80000000, 5'h02, 32'h40000000, 33);
        runOp("mulhu_max",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h03, 32'hFFFFFFFE, 33);
        runOp("mulhsu",     3'd2, 32'hFFFFFFFF, 32'h00000002, 5'h04, 32'hFFFFFFFF, 33);
        runOp("div_neg",    3'd4, 32'hFFFFFFF9, 32'h00000002, 5'h05, 32'hFFFFFFFD, 33);
        runOp("rem_neg",    3'd6, 32'hFFFFFFF9, 32'h00000002, 5'h06, 32'hFFFFFFFF, 33);
        runOp("divu",       3'd5, 32'd100,      32'd7,        5'h07, 32'd14,       33);
        runOp("remu",       3'd7, 32'd100,      32'd7,        5'h08, 32'd2,        33);
        runOp("divu_zero",  3'd5, 32'd5,        32'd0,        5'h09, 32'hFFFFFFFF, 1);
        runOp("rem_zero",   3'd6, 32'd5,        32'd0,        5'h0A, 32'd5,        1);
        runOp("div_ovf",    3'd4, 32'h80000000, 32'hFFFFFFFF, 5'h0B, 32'h80000000, 1);
        runOp("rem_ovf",    3'd6, 32'h80000000, 32'hFFFFFFFF, 5'h0C, 32'h00000000, 1);
        runOp("div_min_z",  3'd4, 32'h80000000, 32'h00000000, 5'h0D, 32'hFFFFFFFF, 1);

        // Response held back for ten cycles, then a handoff in the same cycle it drains.
        resp_rdy = 1'b0;
        applyStimulus(3'd0, 32'd6, 32'd7, 5'h03);
        tick;
        req_val = 1'b0;
        waitResp("hold", cyc);
        repeat (10) tick;
        checkOutput("hold_resp_val", resp_val, 1'b1);
        checkOutput("hold_data", resp_data, 32'd42);
        checkOutput("hold_tag", resp_tag, 5'h03);
        checkOutput("hold_req_rdy", req_rdy, 1'b0);
        applyStimulus(3'd5, 32'd100, 32'd7, 5'h09);
        resp_rdy = 1'b1;
        #1;
        checkOutput("handoff_req_rdy", req_rdy, 1'b1);
        tick;
        req_val = 1'b0;
        checkOutput("handoff_resp_val", resp_val, 1'b0);
        checkOutput("handoff_busy", busy, 1'b1);
        waitResp("handoff", cyc);
        checkOutput("handoff_data", resp_data, 32'd14);
        checkOutput("handoff_tag", resp_tag, 5'h09);
        checkOutput("handoff_latency", cyc, 33);
        tick;

        // Kill an op partway through the iteration.
        applyStimulus(3'd0, 32'd3, 32'd5, 5'h01);
        tick;
        req_val = 1'b0;
        repeat (11) tick;
        squash = 1'b1;
        tick;
        squash = 1'b0;
        checkOutput("squash_calc_busy", busy, 1'b0);
        checkOutput("squash_calc_resp_val", resp_val, 1'b0);
        seen = 0;
        repeat (40) begin
            tick;
            if (resp_val) seen = 1;
        end
        checkOutput("squash_calc_no_resp", seen, 0);
        runOp("after_squash", 3'd4, 32'd1000, 32'hFFFFFFF6, 5'h07, 32'hFFFFFF9C, 33);

        // Kill a result that is waiting in DONE.
        resp_rdy = 1'b0;
        applyStimulus(3'd3, 32'h00010000, 32'h00010000, 5'h02);
        tick;
        req_val = 1'b0;
        waitResp("squash_done", cyc);
        checkOutput("squash_done_data", resp_data, 32'h1);
        squash = 1'b1;
        tick;
        squash = 1'b0;
        resp_rdy = 1'b1;
        checkOutput("squash_done_resp_val", resp_val, 1'b0);
        checkOutput("squash_done_busy", busy, 1'b0);

        // A request offered while squash is high must not be taken.
        squash = 1'b1;
        applyStimulus(3'd0, 32'd2, 32'd2, 5'h04);
        #1;
        checkOutput("squash_idle_req_rdy", req_rdy, 1'b0);
        tick;
        req_val = 1'b0;
        squash  = 1'b0;
        checkOutput("squash_idle_busy", busy, 1'b0);

        // Asynchronous reset between edges while iterating.
        applyStimulus(3'd0, 32'd9, 32'd9, 5'h1F);
        tick;
        req_val = 1'b0;
        repeat (5) tick;
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_busy", busy, 1'b0);
        checkOutput("async_resp_val", resp_val, 1'b0);
        checkOutput("async_resp_data", resp_data, 32'h0);
        checkOutput("async_resp_tag", resp_tag, 5'h0);
        #2;
        reset_n = 1'b1;
        tick;
        runOp("after_reset", 3'd0, 32'd9, 32'd9, 5'h1F, 32'd81, 33);

        // 8-bit instance: overflow fast path and a signed divide.
        val8 = 1'b1; op8 = 3'd4; a8 = 8'h80; b8 = 8'hFF; tag8 = 5'h11;
        tick;
        val8 = 1'b0;
        checkOutput("n8_div_ovf_val", rval8, 1'b1);
        checkOutput("n8_div_ovf_data", data8, 8'h80);
        tick;
        val8 = 1'b1; op8 = 3'd4; a8 = 8'h80; b8 = 8'h03; tag8 = 5'h12;
        tick;
        val8 = 1'b0;
        repeat (8) tick;
        checkOutput("n8_div_val", rval8, 1'b1);
        checkOutput("n8_div_data", data8, 8'hD6);
        tick;

        // 8-bit random sweep with a randomly stalling consumer.
        for (int i = 0; i < 1000; i++) begin
            val8 = 1'b1;
            op8  = 3'($urandom_range(0, 7));
            a8   = pickOperand8();
            b8   = pickOperand8();
            tag8 = 5'($urandom);
            exp8 = refModel8(op8, a8, b8);
            tick;
            val8    = 1'b0;
            got     = 1'b0;
            checked = 1'b0;
            guard   = 0;
            while (!got && guard < 200) begin
                if (rval8) begin
                    checkOutput("sweep_data", data8, exp8);
                    if (!checked) checkOutput("sweep_tag", rtag8, tag8);
                    checked = 1'b1;
                end
                rdy8 = 1'($urandom_range(0, 1));
                tick;
                guard++;
                if (checked && rdy8) got = 1'b1;
            end
            checkOutput("sweep_drained", got, 1'b1);
            rdy8 = 1'b1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
